// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex driver for a 7-segment bank. The displayed value is
// snapshotted once per frame so a scan never mixes nibbles from two input values.
module seg7_scan_display #(
  parameter  int SCAN_DIV = 100000,
  localparam int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [2:0]  which,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       which_q, which_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q, tick_d;
  logic [7:0]       nz_above;
  logic [3:0]       nibble;
  logic             blanked;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    which_d = which_q;
    snap_d  = snap_q;
    tick_d  = 1'b0;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d   = '0;
      which_d = which_q + 3'd1;
      if (which_q == 3'd7) begin
        snap_d = data;
        tick_d = 1'b1;
      end
    end
  end

  // nz_above[i]: some nibble at position i or higher is non-zero in the post-edge snapshot
  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz_above[gi] = |snap_d[31:4*gi];
  end

  // Segments are computed from the post-edge digit so they never lag which
  always_comb begin
    nibble  = snap_d[{which_d, 2'b00} +: 4];
    blanked = blank_lz && (which_d != 3'd0) && !nz_above[which_d];
    seg_d   = {~dp_mask[which_d], blanked ? 7'h7F : hex7(nibble)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      which_q <= 3'd0;
      snap_q  <= 32'h0;
      seg_q   <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      which_q <= which_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign which      = which_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: expected outputs per clock edge come from an
// arithmetic model of the scan (digit = edge/SCAN_DIV mod 8, snapshot on each frame boundary).
module tb_seg7_scan_display;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        blank_lz = 1'b0;
  logic [7:0]  dp_mask = 8'h0;
  logic [2:0]  which;
  logic [7:0]  seg;
  logic        frame_tick;

  seg7_scan_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .which(which), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [2:0] w;
    logic [7:0] s;
    logic       t;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int exp_ticks = 0;
  int dut_ticks = 0;
  logic [31:0] snap = 32'h0;
  logic [6:0] hex_tab [16];

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  function automatic logic [7:0] model_seg(int w, logic [31:0] s, logic bl, logic [7:0] dp);
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        blank;
    upper = s >> (4 * w);
    nib   = upper[3:0];
    blank = bl && (w > 0) && (upper == 32'h0);
    return {~dp[w], blank ? 7'h7F : hex_tab[nib]};
  endfunction

  // One clock edge: inputs are already stable; model the edge and push the expectation
  task automatic step();
    exp_t e;
    @(posedge clk);
    k++;
    e.t = 1'b0;
    if (k % (8 * SD) == 0) begin
      snap = data;
      e.t = 1'b1;
      exp_ticks++;
    end
    e.k = k;
    e.w = 3'((k / SD) % 8);
    e.s = model_seg(int'(e.w), snap, blank_lz, dp_mask);
    q.push_back(e);
    #1;
  endtask

  task automatic run(int n, logic [31:0] d, logic bl, logic [7:0] dp);
    data = d; blank_lz = bl; dp_mask = dp;
    repeat (n) step();
  endtask

  task automatic run_random(int n);
    repeat (n) begin
      data     = $urandom >> $urandom_range(0, 31);
      blank_lz = 1'($urandom);
      dp_mask  = 8'($urandom);
      step();
    end
  endtask

  // Monitor: the DUT presents a fresh output every cycle; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && frame_tick) dut_ticks++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (which !== e.w || seg !== e.s || frame_tick !== e.t) begin
          n_bad++;
          $display("FAIL scan edge=%0d: got which=%0d seg=%02h tick=%b, expected which=%0d seg=%02h tick=%b",
                   e.k, which, seg, frame_tick, e.w, e.s, e.t);
        end else begin
          $display("edge=%0d which=%0d seg=%02h tick=%b ok", e.k, which, seg, frame_tick);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (which !== 3'd0 || seg !== 8'hFF || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got which=%0d seg=%02h tick=%b, expected 0/FF/0", which, seg, frame_tick);
    end
    rst_n = 1'b1; k = 0; snap = 32'h0;

    run(13, 32'h1234ABCD, 1'b0, 8'h00);
    // Reset mid-scan: must act without a clock edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (which !== 3'd0 || seg !== 8'hFF || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got which=%0d seg=%02h tick=%b, expected 0/FF/0", which, seg, frame_tick);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1; k = 0; snap = 32'h0;

    run(44, 32'h1234ABCD, 1'b0, 8'h00);   // first frame shows 0, then 1234ABCD; ends on digit 3
    run(60, 32'hFFFFFFFF, 1'b0, 8'h00);   // mid-frame change must not tear
    run(64, 32'h000000F0, 1'b1, 8'h00);
    run(64, 32'h00000000, 1'b1, 8'h00);
    run(64, 32'h00000000, 1'b1, 8'h81);
    run(5 * 8 * SD, 32'hDEAD0042, 1'b1, 8'h10);
    run_random(320);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    n_cmp++;
    if (dut_ticks != exp_ticks) begin
      n_bad++;
      $display("FAIL tick_count: got %0d, expected %0d", dut_ticks, exp_ticks);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
